dma_cfg_slave: RTL and testbench

- Bus-side responder for the DMA engine.
- Accepts single-beat AXI-style writes and reads from the CPU and holds the DMA configuration registers (enable, source, destination, length). It drives these directly into the DMA engine.
- Exposes the engine's done/interrupt level as a read-only status register.
- Sits between the bus interconnect and the DMA engine.

---
 rtl/dma_cfg_slave_pkg.sv | 33 +++
 rtl/dma_cfg_slave_if.sv | 42 ++++
 rtl/dma_cfg_slave_regfile.sv | 80 ++++++++
 rtl/dma_cfg_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_dma_cfg_slave.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_cfg_slave_pkg.sv
// Shared definitions for the DMA configuration slave: register offsets,
// response encodings, channel FSM states and the byte-lane merge helper.
package dma_pkg;

  localparam logic [2:0] OFF_EN     = 3'd0;
  localparam logic [2:0] OFF_SRC    = 3'd1;
  localparam logic [2:0] OFF_DST    = 3'd2;
  localparam logic [2:0] OFF_LEN    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Replace only the byte lanes selected by strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  // EN..LEN accept writes; STATUS and the unmapped holes do not.
  function automatic logic off_writable(input logic [2:0] off);
    return (off <= OFF_LEN);
  endfunction

endpackage

// File: rtl/dma_cfg_slave_if.sv
// Single-beat AXI-style bus between the CPU interconnect and the DMA config slave.
interface dma_cfg_slave_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
           arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
           arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dma_cfg_slave_regfile.sv
// DMA configuration register storage: strobe-masked write port and a
// combinational read mux that also folds in the engine status bit.
module dma_cfg_regfile
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [2:0]  wr_off_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  input  logic [2:0]  rd_off_i,
  input  logic        status_i,
  output logic [31:0] rd_data_o,
  output logic        rd_err_o,
  output logic        en_o,
  output logic [31:0] src_o,
  output logic [31:0] dst_o,
  output logic [31:0] len_o
);

  logic        en_q,  en_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;

  // Next register values: merge the strobed lanes into the addressed register.
  always_comb begin
    en_d  = en_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    if (we_i) begin
      case (wr_off_i)
        OFF_EN:  en_d  = wr_strb_i[0] ? wr_data_i[0] : en_q;
        OFF_SRC: src_d = apply_strb(src_q, wr_data_i, wr_strb_i);
        OFF_DST: dst_d = apply_strb(dst_q, wr_data_i, wr_strb_i);
        OFF_LEN: len_d = apply_strb(len_q, wr_data_i, wr_strb_i);
        default: en_d  = en_q;
      endcase
    end else begin
      en_d = en_q;
    end
  end

  // Register storage, cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= 1'b0;
      src_q <= 32'd0;
      dst_q <= 32'd0;
      len_q <= 32'd0;
    end else begin
      en_q  <= en_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
    end
  end

  // Read mux; unmapped offsets read zero and flag an error.
  always_comb begin
    rd_data_o = 32'd0;
    rd_err_o  = 1'b0;
    case (rd_off_i)
      OFF_EN:     rd_data_o = {31'd0, en_q};
      OFF_SRC:    rd_data_o = src_q;
      OFF_DST:    rd_data_o = dst_q;
      OFF_LEN:    rd_data_o = len_q;
      OFF_STATUS: rd_data_o = {31'd0, status_i};
      default:    rd_err_o  = 1'b1;
    endcase
  end

  assign en_o  = en_q;
  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;

endmodule

// File: rtl/dma_cfg_slave.sv
// DMA configuration slave: write and read channel FSMs in front of the
// config register file that drives the DMA engine.
module dma_cfg_slave
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  dma_cfg_slave_if.slave    bus,
  input  logic              interrupt_dma,
  output logic              DMAEN,
  output logic [31:0]       DMASRC,
  output logic [31:0]       DMADST,
  output logic [31:0]       DMALEN
);

  // ---------------- write channel ----------------
  w_state_e        w_state_q, w_state_d;
  logic            aw_held_q, aw_held_d;
  logic            w_held_q,  w_held_d;
  logic [ID_W-1:0] awid_q,    awid_d;
  logic [2:0]      awoff_q,   awoff_d;
  logic [31:0]     wdata_q,   wdata_d;
  logic [3:0]      wstrb_q,   wstrb_d;
  logic            awready_q, awready_d;
  logic            wready_q,  wready_d;
  logic            bvalid_q,  bvalid_d;
  logic [ID_W-1:0] bid_q,     bid_d;
  logic [1:0]      bresp_q,   bresp_d;
  logic            commit_s;

  assign commit_s = (w_state_q == W_IDLE) && aw_held_q && w_held_q;

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  // Write FSM next state: commit once both halves are held, leave on B handshake.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  w_state_d = commit_s ? W_RESP : W_IDLE;
      W_RESP:  w_state_d = bus.bready ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: capture AW/W independently, raise B on commit.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awid_d    = awid_q;
    awoff_d   = awoff_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awready_d = 1'b0;
          awid_d    = bus.awid;
          awoff_d   = bus.awaddr[4:2];
        end else begin
          aw_held_d = aw_held_q;
        end
        if (bus.wvalid && wready_q) begin
          w_held_d = 1'b1;
          wready_d = 1'b0;
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
        end else begin
          w_held_d = w_held_q;
        end
        if (commit_s) begin
          bvalid_d = 1'b1;
          bid_d    = awid_q;
          bresp_d  = off_writable(awoff_q) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          bvalid_d = 1'b0;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: bvalid_d = 1'b0;
    endcase
  end

  // Write channel registers; reset drops any pending capture or response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awid_q    <= '0;
      awoff_q   <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awid_q    <= awid_d;
      awoff_q   <= awoff_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------- read channel ----------------
  r_state_e        r_state_q, r_state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q,  rvalid_d;
  logic [ID_W-1:0] rid_q,     rid_d;
  logic [31:0]     rdata_q,   rdata_d;
  logic [1:0]      rresp_q,   rresp_d;
  logic [31:0]     rd_data_s;
  logic            rd_err_s;

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  // Read FSM next state: one outstanding read at a time.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  r_state_d = (bus.arvalid && arready_q) ? R_DATA : R_IDLE;
      R_DATA:  r_state_d = bus.rready ? R_IDLE : R_DATA;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs: snapshot the register file at AR handshake, hold until R handshake.
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = bus.arid;
          rdata_d   = rd_data_s;
          rresp_d   = rd_err_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: rvalid_d = 1'b0;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------- register file ----------------
  dma_cfg_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (commit_s && off_writable(awoff_q)),
    .wr_off_i  (awoff_q),
    .wr_data_i (wdata_q),
    .wr_strb_i (wstrb_q),
    .rd_off_i  (bus.araddr[4:2]),
    .status_i  (interrupt_dma),
    .rd_data_o (rd_data_s),
    .rd_err_o  (rd_err_s),
    .en_o      (DMAEN),
    .src_o     (DMASRC),
    .dst_o     (DMADST),
    .len_o     (DMALEN)
  );

  // Only address bits [4:2] are decoded.
  logic unused_addr_s;
  assign unused_addr_s = ^{bus.awaddr[ADDR_W-1:5], bus.awaddr[1:0],
                           bus.araddr[ADDR_W-1:5], bus.araddr[1:0]};

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rvalid_q;

endmodule

// File: tb/tb_dma_cfg_slave.sv
// Directed bench for dma_cfg_slave with hand-computed expectations.
module tb_dma_cfg_slave;

  logic clk;
  logic rst;
  logic interrupt_dma;
  logic DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  int total;
  int bad;

  dma_cfg_slave_if #(.ADDR_W(32), .ID_W(8)) bus ();

  dma_cfg_slave #(.ADDR_W(32), .ID_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .interrupt_dma (interrupt_dma),
    .DMAEN         (DMAEN),
    .DMASRC        (DMASRC),
    .DMADST        (DMADST),
    .DMALEN        (DMALEN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bvalid(input string tag);
    int n;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_bvalid"}, {31'd0, bus.bvalid}, 32'd1);
  endtask

  // AW and W in the same cycle, bready high; checks B response.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [7:0] id,
                          input logic [1:0] exp_resp, input string tag);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
    bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wait_bvalid(tag);
    check({tag, "_bresp"}, {30'd0, bus.bresp}, {30'd0, exp_resp});
    check({tag, "_bid"}, {24'd0, bus.bid}, {24'd0, id});
    tick();
    check({tag, "_bdone"}, {31'd0, bus.bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] id,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input string tag);
    int n;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
    check({tag, "_rdata"}, bus.rdata, exp_data);
    check({tag, "_rresp"}, {30'd0, bus.rresp}, {30'd0, exp_resp});
    tick();
    check({tag, "_rdone"}, {31'd0, bus.rvalid}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    interrupt_dma = 1'b0;
    bus.awid = 8'd0; bus.awaddr = 32'd0; bus.awvalid = 1'b0;
    bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = 8'd0; bus.araddr = 32'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) tick();
    check("rst_awready", {31'd0, bus.awready}, 32'd1);
    check("rst_wready", {31'd0, bus.wready}, 32'd1);
    check("rst_arready", {31'd0, bus.arready}, 32'd1);
    check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_dmalen", DMALEN, 32'd0);
    rst = 1'b0;
    tick();

    // 1: AW+W together to SRC
    bus.awvalid = 1'b1; bus.awaddr = 32'h04; bus.awid = 8'h5A;
    bus.wvalid = 1'b1; bus.wdata = 32'h0000_1000; bus.wstrb = 4'hF; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t1_awready", {31'd0, bus.awready}, 32'd0);
    check("t1_wready", {31'd0, bus.wready}, 32'd0);
    check("t1_bvalid_early", {31'd0, bus.bvalid}, 32'd0);
    tick();
    check("t1_bvalid", {31'd0, bus.bvalid}, 32'd1);
    check("t1_bresp", {30'd0, bus.bresp}, 32'd0);
    check("t1_bid", {24'd0, bus.bid}, 32'h5A);
    check("t1_src", DMASRC, 32'h0000_1000);
    tick();
    check("t1_bdone", {31'd0, bus.bvalid}, 32'd0);
    check("t1_awready_back", {31'd0, bus.awready}, 32'd1);

    // 2: W three cycles ahead of AW, partial strobe into LEN
    do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 8'h20, 2'b00, "t2_pre");
    check("t2_len_pre", DMALEN, 32'hFFFF_FFFF);
    bus.wvalid = 1'b1; bus.wdata = 32'hAAAA_5555; bus.wstrb = 4'b0011;
    tick();
    bus.wvalid = 1'b0;
    check("t2_wready", {31'd0, bus.wready}, 32'd0);
    check("t2_awready", {31'd0, bus.awready}, 32'd1);
    tick();
    tick();
    check("t2_no_b_yet", {31'd0, bus.bvalid}, 32'd0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h0C; bus.awid = 8'h21;
    tick();
    bus.awvalid = 1'b0;
    tick();
    check("t2_bvalid", {31'd0, bus.bvalid}, 32'd1);
    check("t2_bid", {24'd0, bus.bid}, 32'h21);
    check("t2_len", DMALEN, 32'hFFFF_5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_single_b", {31'd0, bus.bvalid}, 32'd0);
    end

    // 3: STATUS read with rready held low
    interrupt_dma = 1'b1;
    bus.arvalid = 1'b1; bus.araddr = 32'h10; bus.arid = 8'h33; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    interrupt_dma = 1'b0;
    check("t3_arready", {31'd0, bus.arready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("t3_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("t3_rdata", bus.rdata, 32'd1);
      check("t3_rresp", {30'd0, bus.rresp}, 32'd0);
      check("t3_rlast", {31'd0, bus.rlast}, 32'd1);
      check("t3_rid", {24'd0, bus.rid}, 32'h33);
      if (i < 4) tick();
    end
    bus.rready = 1'b1;
    tick();
    check("t3_rdone", {31'd0, bus.rvalid}, 32'd0);
    check("t3_arready_back", {31'd0, bus.arready}, 32'd1);

    // 4: writes to STATUS / unmapped, unmapped read
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 8'h41, 2'b10, "t4_wstat");
    do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 8'h42, 2'b10, "t4_wunm");
    check("t4_en", {31'd0, DMAEN}, 32'd0);
    check("t4_src", DMASRC, 32'h0000_1000);
    check("t4_dst", DMADST, 32'd0);
    check("t4_len", DMALEN, 32'hFFFF_5555);
    do_read(32'h18, 8'h43, 32'd0, 2'b10, "t4_runm");

    // EN: only bit0 stored, strobe 0 leaves it alone
    do_write(32'h00, 32'hFFFF_FFFF, 4'hF, 8'h50, 2'b00, "en_set");
    check("en_set_out", {31'd0, DMAEN}, 32'd1);
    do_read(32'h00, 8'h51, 32'd1, 2'b00, "en_read");
    do_write(32'h00, 32'd0, 4'h0, 8'h52, 2'b00, "en_nostrb");
    check("en_nostrb_out", {31'd0, DMAEN}, 32'd1);
    do_write(32'h00, 32'd0, 4'h1, 8'h53, 2'b00, "en_clr");
    check("en_clr_out", {31'd0, DMAEN}, 32'd0);

    // 5: read and write of DST in the same cycle
    do_write(32'h08, 32'h20, 4'hF, 8'h60, 2'b00, "t5_pre");
    bus.arvalid = 1'b1; bus.araddr = 32'h08; bus.arid = 8'h61; bus.rready = 1'b1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h08; bus.awid = 8'h62;
    bus.wvalid = 1'b1; bus.wdata = 32'h40; bus.wstrb = 4'hF; bus.bready = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t5_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check("t5_rdata_old", bus.rdata, 32'h20);
    tick();
    check("t5_bvalid", {31'd0, bus.bvalid}, 32'd1);
    check("t5_dst_new", DMADST, 32'h40);
    check("t5_rdone", {31'd0, bus.rvalid}, 32'd0);
    tick();

    // 6: reset while a B response is pending
    bus.bready = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = 32'h08; bus.awid = 8'h70;
    bus.wvalid = 1'b1; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wait_bvalid("t6_pend");
    check("t6_src_before", DMASRC, 32'h0000_1000);
    rst = 1'b1;
    #1;
    check("t6_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("t6_src", DMASRC, 32'd0);
    check("t6_dst", DMADST, 32'd0);
    check("t6_awready", {31'd0, bus.awready}, 32'd1);
    check("t6_wready", {31'd0, bus.wready}, 32'd1);
    check("t6_arready", {31'd0, bus.arready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    do_write(32'h04, 32'h0000_2222, 4'hF, 8'h71, 2'b00, "t6_after");
    check("t6_src_after", DMASRC, 32'h0000_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
